cp0_exc_ctrl: RTL

- Parametrised coprocessor-0 and exception controller for the 5-stage pipeline. It sits beside the write-back stage and receives per-instruction exception flags, MTC0/MFC0 requests and external interrupt lines.
- It owns STATUS, CAUSE, EPC, BADVADDR, COUNT and COMPARE. It decides the precise exception or interrupt for the instruction in WB and drives the redirect/cancel bus plus a commit qualifier for the register file.
- It extends the earlier SYSCALL/ERET-only handling with interrupts, a timer, BadVAddr, a prioritised cause and a configurable vector.

---
 rtl/cp0_pkg.sv | 50 +++++
 rtl/cp0_timer.sv | 59 +++++
 rtl/cp0_exc_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared constants, event record and register packing helpers for the CP0 block.
package cp0_pkg;

   localparam logic [7:0] ADDR_BADVADDR = 8'h40;
   localparam logic [7:0] ADDR_COUNT    = 8'h48;
   localparam logic [7:0] ADDR_COMPARE  = 8'h58;
   localparam logic [7:0] ADDR_STATUS   = 8'h60;
   localparam logic [7:0] ADDR_CAUSE    = 8'h68;
   localparam logic [7:0] ADDR_EPC      = 8'h70;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam int STATUS_IE  = 0;
   localparam int STATUS_EXL = 1;
   localparam int CAUSE_TI   = 30;

   localparam int FLG_FETCH = 7;
   localparam int FLG_RI    = 6;
   localparam int FLG_OV    = 5;
   localparam int FLG_SYS   = 4;
   localparam int FLG_BRK   = 3;
   localparam int FLG_RADDR = 2;
   localparam int FLG_WADDR = 1;
   localparam int FLG_ERET  = 0;

   typedef struct packed {
      logic       taken;
      logic       eret;
      logic [4:0] code;
      logic       bad_we;
      logic       bad_pc;
   } exc_evt_t;

   function automatic logic [31:0] pack_status(input logic [7:0] im, input logic exl,
                                               input logic ie);
      return {16'h0000, im, 6'b000000, exl, ie};
   endfunction

   function automatic logic [31:0] pack_cause(input logic ti, input logic [7:0] ip,
                                              input logic [4:0] code);
      return {1'b0, ti, 14'h0000, ip, 1'b0, code, 2'b00};
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// COUNT/COMPARE timer: prescaled COUNT increment and the TI match flag.
module cp0_timer
   import cp0_pkg::*;
#(
   parameter int COUNT_DIV = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        count_we,
   input  logic        compare_we,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(COUNT_DIV - 1);

   logic [PW-1:0] pre_r;
   logic [31:0]   count_r;
   logic [31:0]   compare_r;
   logic          ti_r;
   logic [31:0]   count_inc_s;

   assign count_inc_s = count_r + 32'd1;

   // Prescaler, COUNT, COMPARE and TI; a COMPARE write overrides a same-cycle match.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pre_r     <= '0;
         count_r   <= 32'd0;
         compare_r <= 32'd0;
         ti_r      <= 1'b0;
      end else begin
         if (count_we) begin
            count_r <= wdata;
            pre_r   <= '0;
         end else if (pre_r == PRE_LAST) begin
            pre_r   <= '0;
            count_r <= count_inc_s;
            if (count_inc_s == compare_r) begin
               ti_r <= 1'b1;
            end
         end else begin
            pre_r <= pre_r + PW'(1);
         end
         if (compare_we) begin
            compare_r <= wdata;
            ti_r      <= 1'b0;
         end
      end
   end

   assign count   = count_r;
   assign compare = compare_r;
   assign ti      = ti_r;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 register file and precise exception/interrupt controller at WB.
module cp0_exc_ctrl
   import cp0_pkg::*;
#(
   parameter int          HW_INT_N    = 6,
   parameter logic [31:0] EXC_VECTOR  = 32'h0000_0000,
   parameter int          COUNT_DIV   = 2,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                wb_valid,
   input  logic [31:0]         wb_pc,
   input  logic [7:0]          wb_exc_flags,
   input  logic [31:0]         wb_bad_addr,
   input  logic                mtc0,
   input  logic                mfc0,
   input  logic [7:0]          cp0_addr,
   input  logic [31:0]         cp0_wdata,
   output logic [31:0]         cp0_rdata,
   input  logic [HW_INT_N-1:0] hw_int,
   output logic                exc_valid,
   output logic [31:0]         exc_pc,
   output logic                cancel,
   output logic                wb_commit,
   output logic [31:0]         status_o,
   output logic [31:0]         cause_o,
   output logic [31:0]         epc_o
);

   logic [SYNC_STAGES-1:0][HW_INT_N-1:0] sync_r;
   logic [7:0]  im_r;
   logic        exl_r;
   logic        ie_r;
   logic [1:0]  sw_ip_r;
   logic [4:0]  exc_code_r;
   logic [31:0] epc_r;
   logic [31:0] badvaddr_r;

   logic [31:0] count_s;
   logic [31:0] compare_s;
   logic        ti_s;
   logic [5:0]  hw_ip_s;
   logic [7:0]  ip_s;
   logic        int_req_s;
   exc_evt_t    evt_s;
   logic        wr_s;
   logic [31:0] status_s;
   logic [31:0] cause_s;
   logic [31:0] rdata_s;

   // Interrupt line synchroniser chain.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_r <= '0;
      end else begin
         sync_r[0] <= hw_int;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
      end
   end

   // Hardware IP bits; IP7 doubles as the timer interrupt.
   always_comb begin
      hw_ip_s                 = 6'b000000;
      hw_ip_s[HW_INT_N-1:0]   = sync_r[SYNC_STAGES-1];
      hw_ip_s[5]              = hw_ip_s[5] | ti_s;
   end

   assign ip_s      = {hw_ip_s, sw_ip_r};
   assign int_req_s = ie_r & ~exl_r & (|(ip_s & im_r));

   // Prioritised event decode for the instruction in WB.
   always_comb begin
      evt_s = '0;
      if (wb_valid) begin
         if (int_req_s) begin
            evt_s.taken = 1'b1;
            evt_s.code  = EXC_INT;
         end else if (wb_exc_flags[FLG_FETCH]) begin
            evt_s.taken  = 1'b1;
            evt_s.code   = EXC_ADEL;
            evt_s.bad_we = 1'b1;
            evt_s.bad_pc = 1'b1;
         end else if (wb_exc_flags[FLG_RI]) begin
            evt_s.taken = 1'b1;
            evt_s.code  = EXC_RI;
         end else if (wb_exc_flags[FLG_OV]) begin
            evt_s.taken = 1'b1;
            evt_s.code  = EXC_OV;
         end else if (wb_exc_flags[FLG_SYS]) begin
            evt_s.taken = 1'b1;
            evt_s.code  = EXC_SYS;
         end else if (wb_exc_flags[FLG_BRK]) begin
            evt_s.taken = 1'b1;
            evt_s.code  = EXC_BP;
         end else if (wb_exc_flags[FLG_RADDR]) begin
            evt_s.taken  = 1'b1;
            evt_s.code   = EXC_ADEL;
            evt_s.bad_we = 1'b1;
         end else if (wb_exc_flags[FLG_WADDR]) begin
            evt_s.taken  = 1'b1;
            evt_s.code   = EXC_ADES;
            evt_s.bad_we = 1'b1;
         end else if (wb_exc_flags[FLG_ERET]) begin
            evt_s.eret = 1'b1;
         end else begin
            evt_s.eret = 1'b0;
         end
      end else begin
         evt_s = '0;
      end
   end

   // A faulting instruction never performs its own MTC0.
   assign wr_s = wb_valid & mtc0 & ~evt_s.taken;

   cp0_timer #(
      .COUNT_DIV (COUNT_DIV)
   ) u_timer (
      .clk        (clk),
      .resetn     (resetn),
      .count_we   (wr_s & (cp0_addr == ADDR_COUNT)),
      .compare_we (wr_s & (cp0_addr == ADDR_COMPARE)),
      .wdata      (cp0_wdata),
      .count      (count_s),
      .compare    (compare_s),
      .ti         (ti_s)
   );

   // STATUS/CAUSE/EPC/BADVADDR update: exception entry, MTC0, then ERET.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         im_r       <= 8'h00;
         exl_r      <= 1'b0;
         ie_r       <= 1'b0;
         sw_ip_r    <= 2'b00;
         exc_code_r <= 5'd0;
         epc_r      <= 32'd0;
         badvaddr_r <= 32'd0;
      end else if (evt_s.taken) begin
         exc_code_r <= evt_s.code;
         exl_r      <= 1'b1;
         if (!exl_r) begin
            epc_r <= wb_pc;
         end
         if (evt_s.bad_we) begin
            badvaddr_r <= evt_s.bad_pc ? wb_pc : wb_bad_addr;
         end
      end else begin
         if (wr_s) begin
            case (cp0_addr)
               ADDR_STATUS: begin
                  im_r  <= cp0_wdata[15:8];
                  exl_r <= cp0_wdata[STATUS_EXL];
                  ie_r  <= cp0_wdata[STATUS_IE];
               end
               ADDR_CAUSE: sw_ip_r <= cp0_wdata[9:8];
               ADDR_EPC:   epc_r   <= cp0_wdata;
               default:    ;
            endcase
         end
         if (evt_s.eret) begin
            exl_r <= 1'b0;
         end
      end
   end

   assign status_s = pack_status(im_r, exl_r, ie_r);
   assign cause_s  = pack_cause(ti_s, ip_s, exc_code_r);

   // MFC0 read mux.
   always_comb begin
      rdata_s = 32'd0;
      if (mfc0) begin
         case (cp0_addr)
            ADDR_BADVADDR: rdata_s = badvaddr_r;
            ADDR_COUNT:    rdata_s = count_s;
            ADDR_COMPARE:  rdata_s = compare_s;
            ADDR_STATUS:   rdata_s = status_s;
            ADDR_CAUSE:    rdata_s = cause_s;
            ADDR_EPC:      rdata_s = epc_r;
            default:       rdata_s = 32'd0;
         endcase
      end else begin
         rdata_s = 32'd0;
      end
   end

   assign cp0_rdata = rdata_s;
   assign exc_valid = resetn & (evt_s.taken | evt_s.eret);
   assign cancel    = exc_valid;
   assign exc_pc    = evt_s.taken ? EXC_VECTOR : epc_r;
   assign wb_commit = resetn & wb_valid & ~evt_s.taken;
   assign status_o  = status_s;
   assign cause_o   = cause_s;
   assign epc_o     = epc_r;

endmodule
